// File: rtl/axa_undo_unwinder_pkg.sv
// Shared widths, operand encoding, FSM states and entry layout for the AXA undo stack.
package axa_undo_unwinder_pkg;

  localparam int AXA_DEPTH_LOG2 = 8;
  localparam int AXA_WORD_W     = 16;
  localparam int AXA_REG_W      = 4;
  localparam int AXA_ENTRY_W    = AXA_REG_W + AXA_WORD_W;

  // Operand-type encoding that reads the stack through the peek port.
  localparam logic [1:0] SRC_UNDO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Stored entry layout, MSB first: {dest, data}.
  typedef struct packed {
    logic [AXA_REG_W-1:0]  dest;
    logic [AXA_WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/axa_undo_unwinder_if.sv
// Port bundle of the undo unwinder: push handshake, unwind control, restore port and peek.
// Push handshake: an entry transfers on a posedge where push_valid and push_ready are both 1;
// the master holds push_dest/push_data stable while push_valid is 1.
interface axa_undo_unwinder_if
  import axa_undo_unwinder_pkg::*;
#(
  parameter int DEPTH_LOG2 = AXA_DEPTH_LOG2,
  parameter int WORD_W     = AXA_WORD_W,
  parameter int REG_W      = AXA_REG_W
);
  logic                  push_valid;
  logic                  push_ready;
  logic [REG_W-1:0]      push_dest;
  logic [WORD_W-1:0]     push_data;
  logic                  unwind_req;
  logic [7:0]            unwind_count;
  logic                  wr_en;
  logic [REG_W-1:0]      wr_addr;
  logic [WORD_W-1:0]     wr_data;
  logic                  busy;
  logic                  done;
  logic                  underflow;
  logic [DEPTH_LOG2:0]   depth;
  logic [3:0]            peek_idx;
  logic [WORD_W-1:0]     peek_data;
  state_t                dbg_state;

  modport master (
    output push_valid, push_dest, push_data, unwind_req, unwind_count, peek_idx,
    input  push_ready, wr_en, wr_addr, wr_data, busy, done, underflow, depth,
           peek_data, dbg_state
  );

  modport slave (
    input  push_valid, push_dest, push_data, unwind_req, unwind_count, peek_idx,
    output push_ready, wr_en, wr_addr, wr_data, busy, done, underflow, depth,
           peek_data, dbg_state
  );
endinterface

// File: rtl/axa_undo_unwinder_ram.sv
// One-write / two-read entry store: write for pushes, registered reads for pops and peeks.
// The peek read port exists only when AXA_UNDO_PEEK_EN is defined.
module axa_undo_ram #(
  parameter int AW = 8,
  parameter int DW = 20,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] q_a
`ifdef AXA_UNDO_PEEK_EN
  ,
  input  logic [AW-1:0] raddr_b,
  input  logic          clr_b,
  output logic [PW-1:0] q_b
`endif
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Pop port register doubles as the restore holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_a <= '0;
    else if (re_a) q_a <= mem[raddr_a];
  end

`ifdef AXA_UNDO_PEEK_EN
  // Reads see the array before any same-edge write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q_b <= '0;
    else if (clr_b) q_b <= '0;
    else            q_b <= mem[raddr_b][PW-1:0];
  end
`endif

endmodule

// File: rtl/axa_undo_unwinder.sv
// Undo stack reader: stores {dest, old value} pushes and replays them newest-first on unwind.
// Optional X$ peek port built only when AXA_UNDO_PEEK_EN is defined.
module axa_undo_unwinder
  import axa_undo_unwinder_pkg::*;
#(
  parameter int DEPTH_LOG2 = AXA_DEPTH_LOG2,
  parameter int WORD_W     = AXA_WORD_W,
  parameter int REG_W      = AXA_REG_W
) (
  input  logic                clk,
  input  logic                reset,
  axa_undo_unwinder_if.slave  bus
);

  localparam int ENTRY_W = REG_W + WORD_W;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   sp;
  logic [DEPTH_LOG2:0]     depth_q;
  logic [7:0]              cnt;
  logic                    push_ready_q;
  logic                    wr_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    underflow_q;
  logic                    push_fire;
  logic                    pop_rd;
  logic [ENTRY_W-1:0]      pop_q;

  // push_ready is only high in IDLE, so a handshake implies IDLE.
  assign push_fire = bus.push_valid && push_ready_q;
  assign pop_rd    = (state == ST_READ) && (cnt != 8'd0) && (depth_q != '0);

`ifdef AXA_UNDO_PEEK_EN
  logic [DEPTH_LOG2-1:0] peek_addr;
  logic                  peek_miss;
  logic [WORD_W-1:0]     peek_q;

  assign peek_addr     = sp - 1'b1 - DEPTH_LOG2'(bus.peek_idx);
  assign peek_miss     = (32'(bus.peek_idx) >= 32'(depth_q));
  assign bus.peek_data = peek_q;
`else
  assign bus.peek_data = '0;
`endif

  axa_undo_ram #(
    .AW (DEPTH_LOG2),
    .DW (ENTRY_W),
    .PW (WORD_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (push_fire),
    .waddr   (sp),
    .wdata   ({bus.push_dest, bus.push_data}),
    .re_a    (pop_rd),
    .raddr_a (sp - 1'b1),
    .q_a     (pop_q)
`ifdef AXA_UNDO_PEEK_EN
    ,
    .raddr_b (peek_addr),
    .clr_b   (peek_miss),
    .q_b     (peek_q)
`endif
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      sp           <= '0;
      depth_q      <= '0;
      cnt          <= '0;
      push_ready_q <= 1'b1;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (push_fire) begin
            sp <= sp + 1'b1;
            if (depth_q != FULL) depth_q <= depth_q + 1'b1;
          end
          if (bus.unwind_req) begin
            cnt          <= bus.unwind_count;
            state        <= ST_READ;
            busy_q       <= 1'b1;
            push_ready_q <= 1'b0;
          end
        end
        ST_READ: begin
          if (cnt == 8'd0 || depth_q == '0) begin
            if (cnt != 8'd0) underflow_q <= 1'b1;
            state  <= ST_FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            // Entry lands in the RAM read register while wr_en is raised.
            state   <= ST_WRITE;
            wr_en_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          sp      <= sp - 1'b1;
          depth_q <= depth_q - 1'b1;
          cnt     <= cnt - 8'd1;
          state   <= ST_READ;
        end
        ST_FIN: begin
          state        <= ST_IDLE;
          push_ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.push_ready = push_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = pop_q[ENTRY_W-1:WORD_W];
  assign bus.wr_data    = pop_q[WORD_W-1:0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.underflow  = underflow_q;
  assign bus.depth      = depth_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_axa_undo_unwinder.sv
// Bench for axa_undo_unwinder: directed and random pushes/unwinds/peeks against a queue model.
module tb_axa_undo_unwinder;
  import axa_undo_unwinder_pkg::*;

  localparam int CAP = 256;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // Model: the stack as a queue of {dest, data}, oldest at the front.
  logic [19:0] exp_q[$];
  logic        exp_uf;

  axa_undo_unwinder_if #(.DEPTH_LOG2(8), .WORD_W(16), .REG_W(4)) bus ();

  axa_undo_unwinder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] d, input logic [15:0] v);
    if (exp_q.size() == CAP) void'(exp_q.pop_front());
    exp_q.push_back({d, v});
  endtask

  task automatic push(input logic [3:0] d, input logic [15:0] v);
    bus.push_valid = 1'b1;
    bus.push_dest  = d;
    bus.push_data  = v;
    tick();
    bus.push_valid = 1'b0;
    model_push(d, v);
  endtask

  task automatic peek_check(input int idx);
    logic [15:0] exp;
    bus.peek_idx = idx[3:0];
    tick();
`ifdef AXA_UNDO_PEEK_EN
    exp = (idx < exp_q.size()) ? exp_q[exp_q.size() - 1 - idx][15:0] : 16'h0;
`else
    exp = 16'h0;
`endif
    check("peek_data", bus.peek_data, exp);
  endtask

  // Unwind n entries; optional same-edge push, optional req/push poke while busy.
  task automatic do_unwind(input int n, input bit with_push, input logic [3:0] pd,
                           input logic [15:0] pv, input bit poke);
    logic [19:0] pops[$];
    int k, wi, done_cyc;
    bus.unwind_req   = 1'b1;
    bus.unwind_count = n[7:0];
    if (with_push) begin
      bus.push_valid = 1'b1;
      bus.push_dest  = pd;
      bus.push_data  = pv;
      model_push(pd, pv);
    end
    tick();
    bus.unwind_req = 1'b0;
    bus.push_valid = 1'b0;
    k = 0;
    while (k < n && exp_q.size() > 0) begin
      pops.push_back(exp_q.pop_back());
      k++;
    end
    if (n > k) exp_uf = 1'b1;
    wi       = 0;
    done_cyc = -1;
    for (int c = 1; c <= 2 * n + 8; c++) begin
      if (poke && c == 3) begin
        bus.unwind_req   = 1'b1;
        bus.unwind_count = 8'd7;
        bus.push_valid   = 1'b1;
        bus.push_dest    = 4'hE;
        bus.push_data    = 16'hDEAD;
      end else begin
        bus.unwind_req = 1'b0;
        bus.push_valid = 1'b0;
      end
      if (bus.done === 1'b1) begin
        done_cyc = c;
        check("busy_at_done", bus.busy, 1'b0);
        break;
      end
      check("busy", bus.busy, 1'b1);
      check("push_ready_busy", bus.push_ready, 1'b0);
      check("wr_en", bus.wr_en, (c % 2 == 0) && (c <= 2 * k));
      if (bus.wr_en === 1'b1 && wi < k) begin
        check("wr_addr", bus.wr_addr, pops[wi][19:16]);
        check("wr_data", bus.wr_data, pops[wi][15:0]);
      end
      if (bus.wr_en === 1'b1) wi++;
      tick();
    end
    bus.unwind_req = 1'b0;
    bus.push_valid = 1'b0;
    check("done_cycle", done_cyc, 2 * k + 2);
    check("wr_count", wi, k);
    check("depth_after", bus.depth, exp_q.size());
    check("underflow", bus.underflow, exp_uf);
    tick();
    check("done_pulse", bus.done, 1'b0);
    check("push_ready_idle", bus.push_ready, 1'b1);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    exp_uf = 1'b0;
    check("rst_push_ready", bus.push_ready, 1'b1);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 4'h0);
    check("rst_wr_data", bus.wr_data, 16'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_underflow", bus.underflow, 1'b0);
    check("rst_depth", bus.depth, 9'd0);
    check("rst_peek", bus.peek_data, 16'h0);
    #1 reset = 1'b1;
    tick();
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int prior;
    bus.push_valid   = 1'b0;
    bus.push_dest    = '0;
    bus.push_data    = '0;
    bus.unwind_req   = 1'b0;
    bus.unwind_count = '0;
    bus.peek_idx     = '0;
    reset            = 1'b1;
    exp_uf           = 1'b0;
    #1;
    do_reset();

    // Three pushes replayed newest-first.
    push(4'd1, 16'h1111);
    push(4'd2, 16'h2222);
    push(4'd3, 16'h3333);
    check("depth_3", bus.depth, 9'd3);
    do_unwind(3, 0, 4'd0, 16'h0, 0);

    // Peeks, then an over-long unwind that underflows.
    push(4'd6, 16'hAAAA);
    push(4'd7, 16'hBBBB);
    peek_check(0);
    peek_check(1);
    peek_check(2);
    do_unwind(5, 0, 4'd0, 16'h0, 0);

    // Same-edge push and unwind of one entry.
    push(4'd8, 16'h0808);
    push(4'd9, 16'h0909);
    prior = exp_q.size();
    do_unwind(1, 1, 4'd5, 16'h5555, 0);
    check("depth_prior", bus.depth, prior);

    // Random traffic, including requests and pushes offered while busy.
    for (int it = 0; it < 8; it++) begin
      int np = $urandom_range(0, 12);
      for (int j = 0; j < np; j++) push(4'($urandom_range(0, 15)), 16'($urandom));
      for (int j = 0; j < 3; j++) peek_check($urandom_range(0, 15));
      do_unwind($urandom_range(0, 14), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                16'($urandom), 1'b1);
    end
    check("underflow_sticky", bus.underflow, 1'b1);
    do_reset();

    // Overfill: 257 pushes, oldest entry lost.
    for (int i = 0; i <= 256; i++) push(4'(i), 16'(i));
    check("depth_full", bus.depth, 9'd256);
    peek_check(0);
    peek_check(15);
    do_unwind(200, 0, 4'd0, 16'h0, 0);
    do_unwind(100, 0, 4'd0, 16'h0, 0);

    // Reset during the first restore of a 4-entry unwind.
    do_reset();
    for (int i = 0; i < 4; i++) push(4'(i + 10), 16'($urandom));
    bus.unwind_req   = 1'b1;
    bus.unwind_count = 8'd4;
    tick();
    bus.unwind_req = 1'b0;
    tick();
    check("wr_en_before_rst", bus.wr_en, 1'b1);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    exp_uf = 1'b0;
    check("mid_rst_wr_en", bus.wr_en, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_depth", bus.depth, exp_q.size());
    #1 reset = 1'b1;
    tick();
    check("post_rst_push_ready", bus.push_ready, 1'b1);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_wr_en", bus.wr_en, 1'b0);
    push(4'd4, 16'h4444);
    do_unwind(1, 0, 4'd0, 16'h0, 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
